decode_stage: RTL and testbench

Parametrised, pipelined successor to the single-cycle decode block. Decodes one RV32I instruction per cycle, with optional M-extension decode. Reads operands from an internal register file that has write-back bypass. Registers the full decoded bundle into an ID/EX pipeline register behind valid/ready handshakes. Sits between the fetch stage and the execute stage, and owns load-use hazard stalling and flush handling.

---
 rtl/decode_pkg.sv | 56 +++++
 rtl/regfile_bypass.sv | 39 +++
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALU codes, jump encodings and control bundle for decode_stage
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       mul_en;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       illegal;
    logic [1:0] jump;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - NREGS x XLEN register file, two read ports, one write port, write-through bypass
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < 6'(NREGS);
  endfunction

  // x0 and out-of-range indices read as zero; a same-cycle write is forwarded
  assign rs1_data = (rs1 == 5'd0 || !in_range(rs1)) ? '0 :
                    (wb_en && wb_rd == rs1)          ? wb_data : regs[rs1[AW-1:0]];
  assign rs2_data = (rs2 == 5'd0 || !in_range(rs2)) ? '0 :
                    (wb_en && wb_rd == rs2)          ? wb_data : regs[rs2[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0 && in_range(wb_rd)) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - pipelined RV32I decode with ID/EX register, load-use stall and flush
// Optional M-extension decode enabled by defining DECODE_MUL_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_mul_en,
  output logic            out_branch,
  output logic            out_mem_read,
  output logic            out_mem_to_reg,
  output logic            out_mem_write,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_illegal,
  output logic [1:0]      out_jump
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            use_rs1, use_rs2, use_rd, known, bad_idx;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm, rs1_data, rs2_data;
  ctrl_t           ctrl, out_ctrl;
  logic            load, hazard;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    ctrl    = '0;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    known   = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm32 = {in_instr[31:12], 12'b0};
        use_rd = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        use_rd = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.jump = JUMP_JAL;
      end
      OP_JALR: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.jump = JUMP_JALR;
      end
      OP_BRANCH: begin
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl.branch = 1'b1; ctrl.alu_ctrl = ALU_SUB;
      end
      OP_LOAD: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
      end
      OP_STORE: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        use_rs1 = 1'b1; use_rs2 = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
      end
      OP_IMM: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        use_rs1 = 1'b1; use_rd = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
      end
      OP_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; ctrl.reg_write = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef DECODE_MUL_EN
          ctrl.mul_en   = 1'b1;
          ctrl.alu_ctrl = {1'b0, funct3};
`else
          known = 1'b0;
`endif
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          ctrl.alu_ctrl = alu_from_funct3(funct3, funct7[5]);
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase

    bad_idx = (use_rs1 && {1'b0, in_instr[19:15]} >= 6'(NREGS)) ||
              (use_rs2 && {1'b0, in_instr[24:20]} >= 6'(NREGS)) ||
              (use_rd  && {1'b0, in_instr[11:7]}  >= 6'(NREGS));

    // illegal instructions still flow downstream but must not change architectural state
    if (!known || bad_idx) begin
      ctrl.illegal    = 1'b1;
      ctrl.reg_write  = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.mul_en     = 1'b0;
      ctrl.jump       = JUMP_NONE;
    end
  end

  // unused source fields are zeroed so they never match a hazard or a refresh
  assign dec_rs1 = use_rs1 ? in_instr[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? in_instr[24:20] : 5'd0;
  assign dec_rd  = use_rd  ? in_instr[11:7]  : 5'd0;
  assign dec_imm = XLEN'($signed(imm32));

  regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  assign load     = !out_valid || out_ready;
  assign hazard   = out_valid && out_ctrl.mem_read && out_rd != 5'd0 &&
                    (dec_rs1 == out_rd || dec_rs2 == out_rd);
  assign in_ready = load && !hazard && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_ctrl     <= '0;
    end else if (flush || (load && hazard)) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_pc       <= in_pc;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_imm      <= dec_imm;
        out_rs1      <= dec_rs1;
        out_rs2      <= dec_rs2;
        out_rd       <= dec_rd;
        out_ctrl     <= ctrl;
      end
    end else begin
      if (wb_en && wb_rd != 5'd0 && wb_rd == out_rs1) out_rs1_data <= wb_data;
      if (wb_en && wb_rd != 5'd0 && wb_rd == out_rs2) out_rs2_data <= wb_data;
    end
  end

  assign out_alu_ctrl   = out_ctrl.alu_ctrl;
  assign out_mul_en     = out_ctrl.mul_en;
  assign out_branch     = out_ctrl.branch;
  assign out_mem_read   = out_ctrl.mem_read;
  assign out_mem_to_reg = out_ctrl.mem_to_reg;
  assign out_mem_write  = out_ctrl.mem_write;
  assign out_alu_src    = out_ctrl.alu_src;
  assign out_reg_write  = out_ctrl.reg_write;
  assign out_illegal    = out_ctrl.illegal;
  assign out_jump       = out_ctrl.jump;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven scoreboard bench for decode_stage (expectations follow DECODE_MUL_EN)
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, wb_en, out_ready, in_ready, in_ready_b;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        out_valid, out_mul_en, out_branch, out_mem_read, out_mem_to_reg;
  logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_ctrl;
  logic [1:0]  out_jump;

  logic        out_valid_b, out_mul_en_b, out_branch_b, out_mem_read_b, out_mem_to_reg_b;
  logic        out_mem_write_b, out_alu_src_b, out_reg_write_b, out_illegal_b;
  logic [31:0] out_pc_b, out_rs1_data_b, out_rs2_data_b, out_imm_b;
  logic [4:0]  out_rs1_b, out_rs2_b, out_rd_b;
  logic [3:0]  out_alu_ctrl_b;
  logic [1:0]  out_jump_b;

  decode_stage #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_ctrl(out_alu_ctrl),
    .out_mul_en(out_mul_en), .out_branch(out_branch), .out_mem_read(out_mem_read),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
    .out_alu_src(out_alu_src), .out_reg_write(out_reg_write), .out_illegal(out_illegal),
    .out_jump(out_jump)
  );

  decode_stage #(.XLEN(32), .NREGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .out_rs1_data(out_rs1_data_b), .out_rs2_data(out_rs2_data_b), .out_imm(out_imm_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b), .out_alu_ctrl(out_alu_ctrl_b),
    .out_mul_en(out_mul_en_b), .out_branch(out_branch_b), .out_mem_read(out_mem_read_b),
    .out_mem_to_reg(out_mem_to_reg_b), .out_mem_write(out_mem_write_b),
    .out_alu_src(out_alu_src_b), .out_reg_write(out_reg_write_b), .out_illegal(out_illegal_b),
    .out_jump(out_jump_b)
  );

  typedef struct {
    logic [31:0] instr, pc, rs1d, rs2d, imm;
    logic [3:0]  alu;
    logic        rw, mr, ill, mul;
    logic [1:0]  jump;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[12];
  vec_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pc_ctr = 32'h1000;
  int          stalls;
  logic        ov_acc;

`ifdef DECODE_MUL_EN
  localparam logic MUL_ON = 1'b1;
`else
  localparam logic MUL_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs1d,
                              input logic [31:0] rs2d, input logic [31:0] imm,
                              input logic [3:0] alu, input logic rw, input logic mr,
                              input logic ill, input logic mul, input logic [1:0] jump);
    vec_t v;
    v.instr = instr; v.pc = '0; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
    v.alu = alu; v.rw = rw; v.mr = mr; v.ill = ill; v.mul = mul; v.jump = jump;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: pc %0h with empty scoreboard", out_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("pc",        out_pc,        mon_e.pc);
        chk("rs1_data",  out_rs1_data,  mon_e.rs1d);
        chk("rs2_data",  out_rs2_data,  mon_e.rs2d);
        chk("imm",       out_imm,       mon_e.imm);
        chk("alu_ctrl",  out_alu_ctrl,  mon_e.alu);
        chk("reg_write", out_reg_write, mon_e.rw);
        chk("mem_read",  out_mem_read,  mon_e.mr);
        chk("illegal",   out_illegal,   mon_e.ill);
        chk("mul_en",    out_mul_en,    mon_e.mul);
        chk("jump",      out_jump,      mon_e.jump);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input vec_t v, output int st, output logic ov);
    vec_t e;
    e = v; e.pc = pc_ctr;
    in_instr = v.instr; in_pc = pc_ctr; in_valid = 1'b1;
    st = 0;
    @(negedge clk);
    while (!in_ready && st < 20) begin
      st++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready %0b expected 1 within 20 cycles", in_ready);
    end else begin
      sb.push_back(e);
    end
    ov = out_valid;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_ctr += 32'd4;
    if (out_ready) chk("latency_out_valid", out_valid, 1);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1; in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pc", out_pc, 0);
    chk("reset_rs1_data", out_rs1_data, 0);
    chk("reset_imm", out_imm, 0);
    chk("reset_reg_write", out_reg_write, 0);
    rst = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    wb(5'd5, 32'h1234); wb(5'd1, 32'h100); wb(5'd2, 32'h22); wb(5'd4, 32'h44);

    tbl[0]  = mk(32'h00128313, 32'h1234, 0, 1, ALU_ADD, 1, 0, 0, 0, JUMP_NONE);
    tbl[1]  = mk(32'h402284B3, 32'h1234, 32'h22, 0, ALU_SUB, 1, 0, 0, 0, JUMP_NONE);
    tbl[2]  = mk(32'h0020A423, 32'h100, 32'h22, 8, ALU_ADD, 0, 0, 0, 0, JUMP_NONE);
    tbl[3]  = mk(32'hFE208EE3, 32'h100, 32'h22, 32'hFFFFFFFC, ALU_SUB, 0, 0, 0, 0, JUMP_NONE);
    tbl[4]  = mk(32'h12345537, 0, 0, 32'h12345000, ALU_ADD, 1, 0, 0, 0, JUMP_NONE);
    tbl[5]  = mk(32'h4042D593, 32'h1234, 0, 32'h404, ALU_SRA, 1, 0, 0, 0, JUMP_NONE);
    tbl[6]  = mk(32'h008000EF, 0, 0, 8, ALU_ADD, 1, 0, 0, 0, JUMP_JAL);
    tbl[7]  = mk(32'h0000007F, 0, 0, 0, ALU_ADD, 0, 0, 1, 0, JUMP_NONE);
    tbl[8]  = mk(32'h023100B3, 32'h22, 0, 0, ALU_ADD, MUL_ON, 0, !MUL_ON, MUL_ON, JUMP_NONE);
    tbl[9]  = mk(32'h00008067, 32'h100, 0, 0, ALU_ADD, 1, 0, 0, 0, JUMP_JALR);
    tbl[10] = mk(32'hFFF12693, 32'h22, 0, 32'hFFFFFFFF, ALU_SLT, 1, 0, 0, 0, JUMP_NONE);
    tbl[11] = mk(32'h0020F733, 32'h100, 32'h22, 0, ALU_AND, 1, 0, 0, 0, JUMP_NONE);

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i], stalls, ov_acc);
      chk("table_no_stall", stalls, 0);
    end
    drain();

    // load-use: lw x7,0(x1) then add x8,x7,x2; x7 written back during the bubble
    issue(mk(32'h0000A383, 32'h100, 0, 0, ALU_ADD, 1, 1, 0, 0, JUMP_NONE), stalls, ov_acc);
    chk("lw_no_stall", stalls, 0);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    issue(mk(32'h00238433, 32'h77, 32'h22, 0, ALU_ADD, 1, 0, 0, 0, JUMP_NONE), stalls, ov_acc);
    wb_en = 1'b0;
    chk("hazard_stall_cycles", stalls, 1);
    chk("hazard_bubble", ov_acc, 0);
    drain();

    // held operand refresh: add x3,x4,x5 held while x4 is rewritten
    out_ready = 1'b0;
    issue(mk(32'h005201B3, 32'hAA, 32'h1234, 0, ALU_ADD, 1, 0, 0, 0, JUMP_NONE), stalls, ov_acc);
    chk("held_valid", out_valid, 1);
    chk("held_rs1_before", out_rs1_data, 32'h44);
    wb(5'd4, 32'hAA);
    chk("held_rs1_refresh", out_rs1_data, 32'hAA);
    chk("held_valid_after_wb", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("held_drained", out_valid, 0);

    // flush with a held instruction and a presented instruction
    out_ready = 1'b0;
    issue(tbl[0], stalls, ov_acc);
    in_instr = 32'h402284B3; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    sb.delete(sb.size() - 1);
    out_ready = 1'b1;
    drain();

    // NREGS=16: x20 is out of range; x0 ignores write-back
    issue(mk(32'h00100A13, 0, 0, 1, ALU_ADD, 1, 0, 0, 0, JUMP_NONE), stalls, ov_acc);
    chk("rv32e_valid", out_valid_b, 1);
    chk("rv32e_illegal", out_illegal_b, 1);
    chk("rv32e_reg_write", out_reg_write_b, 0);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    issue(mk(32'h00500613, 0, 0, 5, ALU_ADD, 1, 0, 0, 0, JUMP_NONE), stalls, ov_acc);
    wb_en = 1'b0;
    chk("rv32e_x0_reads_zero", out_rs1_data_b, 0);
    chk("rv32e_legal_addi", out_illegal_b, 0);
    drain();

    // reset while an instruction is held
    out_ready = 1'b0;
    issue(tbl[1], stalls, ov_acc);
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_rs1_data", out_rs1_data, 0);
    sb.delete(sb.size() - 1);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
